axi_slave_wr_ctrl: RTL

AXI4 slave write-path controller that sits directly downstream of the bus driven by the environment's master agent over `axi_interface`. It accepts one write burst at a time on the AW/W channels, computes per-beat addresses for FIXED, INCR and WRAP bursts, including narrow and unaligned transfers, and drives a byte-enabled memory write port. It returns a single B response per burst.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_addr_gen.sv | 53 +++++
 rtl/axi_slave_wr_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types for the AXI4 slave write path: burst encodings, response codes,
// write-controller FSM states and the WRAP length legality helper.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational beat-address sequencer: next address for FIXED/INCR/WRAP and
// the byte-lane mask of the current (possibly narrow or unaligned) beat.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_size,
  input  logic [7:0]          i_len,
  input  burst_e              i_burst,
  output logic [ADDR_W-1:0]   o_next_addr,
  output logic [DATA_W/8-1:0] o_lane_mask
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  logic [ADDR_W-1:0] w_size_b;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wrap_b;
  logic [ADDR_W-1:0] w_wrap_lo;
  logic [8:0]        w_s9;
  logic [8:0]        w_off9;
  logic [8:0]        w_hi9;

  assign w_size_b  = ADDR_W'(1) << i_size;
  assign w_incr    = (i_addr & ~(w_size_b - ADDR_W'(1))) + w_size_b;
  assign w_wrap_b  = (ADDR_W'(i_len) + ADDR_W'(1)) << i_size;
  assign w_wrap_lo = i_addr & ~(w_wrap_b - ADDR_W'(1));

  always_comb begin
    case (i_burst)
      FIXED:   o_next_addr = i_addr;
      WRAP:    o_next_addr = (w_incr == w_wrap_lo + w_wrap_b) ? w_wrap_lo : w_incr;
      default: o_next_addr = w_incr;
    endcase
  end

  // Active lanes run from the start offset up to the next size boundary.
  assign w_s9   = 9'(1) << i_size;
  assign w_off9 = 9'(i_addr[LB-1:0]);
  assign w_hi9  = (w_off9 & ~(w_s9 - 9'd1)) + w_s9;

  always_comb begin
    o_lane_mask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      o_lane_mask[i] = (9'(i) >= w_off9) && (9'(i) < w_hi9);
    end
  end

endmodule

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 slave write controller: one burst at a time, byte-enabled memory port,
// single B response. Define AXI_WRAP_LEN_CHECK_EN to reject illegal WRAP lengths.
module axi_slave_wr_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  state_e              r_state, w_state_nxt;
  logic                r_awready, r_wready, r_bvalid;
  logic                w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len, r_beat;
  logic [2:0]          r_size;
  burst_e              r_burst, w_burst_in;
  logic                r_err, r_bad;
  logic [1:0]          r_bresp;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [NB-1:0]       r_mem_wstrb;
  logic                w_aw_hs, w_w_hs, w_b_hs;
  logic                w_last_beat, w_wlast_err, w_lenchk_bad, w_req_bad;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [NB-1:0]       w_lane_mask;

  assign w_aw_hs     = awvalid && r_awready;
  assign w_w_hs      = wvalid && r_wready;
  assign w_b_hs      = bready && r_bvalid;
  assign w_last_beat = (r_beat == r_len);
  assign w_wlast_err = (wlast != w_last_beat);

  always_comb begin
    w_lenchk_bad = 1'b0;
    case (awburst)
      2'b00: w_burst_in = FIXED;
      2'b10: begin
`ifdef AXI_WRAP_LEN_CHECK_EN
        w_burst_in   = WRAP;
        w_lenchk_bad = !wrap_len_legal(awlen);
`else
        w_burst_in   = wrap_len_legal(awlen) ? WRAP : INCR;
`endif
      end
      default: w_burst_in = INCR;
    endcase
  end

  assign w_req_bad = (int'(awsize) > LB) || (awburst == 2'b11) || w_lenchk_bad;

  axi_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_lane_mask (w_lane_mask)
  );

  // Handshake outputs are registered from the next state, so awready stays
  // low for the first cycle out of reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs) w_state_nxt = DATA;
      DATA:    if (w_w_hs && w_last_beat) w_state_nxt = RESP;
      RESP:    if (w_b_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_awready_nxt = (w_state_nxt == IDLE);
    w_wready_nxt  = (w_state_nxt == DATA);
    w_bvalid_nxt  = (w_state_nxt == RESP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= FIXED;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_bad       <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_aw_hs) begin
        r_id    <= awid;
        r_addr  <= awaddr;
        r_len   <= awlen;
        r_size  <= awsize;
        r_burst <= w_burst_in;
        r_beat  <= '0;
        r_err   <= 1'b0;
        r_bad   <= w_req_bad;
      end
      if (w_w_hs) begin
        r_mem_we    <= !r_bad;
        r_mem_addr  <= r_addr & ~ADDR_W'(NB - 1);
        r_mem_wdata <= wdata;
        r_mem_wstrb <= wstrb & w_lane_mask;
        r_addr      <= w_next_addr;
        r_beat      <= r_beat + 8'd1;
        r_err       <= r_err | w_wlast_err;
        if (w_last_beat) begin
          r_bresp <= (r_err || w_wlast_err || r_bad) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_id;
  assign bresp     = r_bresp;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
